// File: rtl/div_64.sv
// rtl/div_64.sv - iterative radix-2 restoring divider, signed/unsigned, RISC-V M corner cases
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             early;
    logic             short_path;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic             unused_rem_msb;

    assign accept   = in_valid & in_ready & ~flush;
    assign a_neg    = div_signed & dividend[WIDTH-1];
    assign b_neg    = div_signed & divisor[WIDTH-1];
    assign a_mag    = a_neg ? -dividend : dividend;
    assign b_mag    = b_neg ? -divisor : divisor;
    assign div_zero = (divisor == '0);
    assign overflow = div_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign short_path = div_zero | overflow | early;

    // The partial remainder is always below |divisor|, so its top bit only matters after the shift.
    assign shifted        = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign ge             = (shifted >= {1'b0, dsr});
    assign unused_rem_msb = rem[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = short_path ? DONE : CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        dvd    <= a_mag;
                        dsr    <= b_mag;
                        rem    <= '0;
                        cnt    <= '0;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (overflow) begin
                            quotient  <= dividend;
                            remainder <= '0;
                        end else if (early) begin
                            quotient  <= '0;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    rem <= ge ? (shifted - {1'b0, dsr}) : shifted;
                    dvd <= {dvd[WIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= sign_q ? -dvd : dvd;
                    remainder <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_64.sv
// tb/tb_div_64.sv - self-checking bench for div_64: vector table, random ops vs arithmetic model, corner sequences
module tb_div_64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int passed = 0;
    int total = 0;

    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    div_64 #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .div_signed(div_signed), .dividend(dividend), .divisor(divisor), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] mag(input logic sgn, input logic [63:0] x);
        return (sgn && x[63]) ? 64'd0 - x : x;
    endfunction

    task automatic ref_div(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r);
        longint sa, sb;
        sa = a;
        sb = b;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (sgn && a == MIN_NEG && b == '1) begin
            q = a;
            r = 64'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return 1;
        if (sgn && a == MIN_NEG && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag(sgn, a) < mag(sgn, b)) return 1;
`endif
        return 66;
    endfunction

    task automatic start_op(input logic sgn, input logic [63:0] a, input logic [63:0] b);
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_result(output int lat, output logic rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er);
        int   lat;
        logic rdy_seen;
        out_ready = 1'b1;
        start_op(sgn, a, b);
        wait_result(lat, rdy_seen);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat(sgn, a, b)));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " in_ready low while busy"}, {63'd0, rdy_seen}, 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " idle after retire"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        vec_t        vecs[9];
        logic [63:0] mq, mr;
        int          lat, cnt_ov;
        logic        rdy_seen;

        vecs[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2};
        vecs[3] = '{1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        vecs[4] = '{1'b1, MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, MIN_NEG, 64'd0};
        vecs[5] = '{1'b0, 64'd5, 64'd9, 64'd0, 64'd5};
        vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[7] = '{1'b0, MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, MIN_NEG};
        vecs[8] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

        #12;
        chk("reset in_ready/out_valid", {62'd0, in_ready, out_valid}, 64'd2);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        start_op(1'b0, 64'd100, 64'd7);
        wait_result(lat, rdy_seen);
        chk("bp latency", 64'(lat), 64'd66);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid/ready", {62'd0, in_ready, out_valid}, 64'd1);
            chk("bp hold quotient", quotient, 64'd14);
            chk("bp hold remainder", remainder, 64'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp retire", {62'd0, in_ready, out_valid}, 64'd2);

        // Flush in CALC cycle 20.
        start_op(1'b0, 64'd1000, 64'd3);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush idle", {62'd0, in_ready, out_valid}, 64'd2);
        cnt_ov = 0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid || !in_ready) cnt_ov++;
            @(posedge clk);
            #1;
        end
        chk("flush no result / no accept", 64'(cnt_ov), 64'd0);
        chk("flush keeps quotient", quotient, 64'd14);

        for (int i = 0; i < 25; i++) begin
            logic        sgn;
            logic [63:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: b = sgn && $urandom_range(0, 1) ? 64'd0 - 64'($urandom_range(1, 20)) : 64'($urandom_range(1, 20));
                2: begin a = MIN_NEG; b = '1; end
                3: begin a = 64'($urandom_range(0, 1000)); b = {$urandom, $urandom}; end
                default: b = {32'd0, $urandom} >> $urandom_range(0, 31);
            endcase
            ref_div(sgn, a, b, mq, mr);
            run_op($sformatf("rnd%0d", i), sgn, a, b, mq, mr);
        end

        // Reset in the middle of CALC.
        start_op(1'b0, 64'd777, 64'd5);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset valid/ready", {62'd0, in_ready, out_valid}, 64'd2);
        chk("midreset quotient", quotient, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post reset", 1'b0, 64'd777, 64'd5, 64'd155, 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_64.md
Name: div_64

Overview:
- Iterative radix-2 integer divider, the inverse-operation companion to the 64-bit multiplier datapath.
- Accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle with a restoring shift-subtract loop.
- Returns quotient and remainder over a second valid/ready handshake.
- Supports signed and unsigned operands with RISC-V M-extension semantics for the corner cases.

Parameters:
- WIDTH, 64, operand/result width in bits; must be ≥ 4 and even.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- div_signed  input  1  1 = signed operands, 0 = unsigned; sampled at accept.
- dividend  input  WIDTH  dividend; sampled at accept.
- divisor  input  WIDTH  divisor; sampled at accept.
- flush  input  1  abort the current operation; highest priority.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, quotient = 0, remainder = 0.
  - All internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge (accept edge T0), operands, div_signed and result signs are captured.
  - Result signs: sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend); both 0 when unsigned.
  - Magnitudes are taken by two's-complement negation of negative signed operands.
- Special cases, decided at T0 with no iteration; next state DONE, so out_valid is high in cycle T0+1:
  - Divisor == 0: quotient = all ones, remainder = dividend (original, unmodified).
  - Signed with dividend == 100..0 and divisor == all ones: quotient = dividend, remainder = 0.
- Otherwise next state CALC with iteration counter = 0 and partial remainder = 0.
- CALC, exactly WIDTH cycles:
  - Each cycle: shift {rem, dvd} left by 1.
  - If rem ≥ |divisor|: rem -= |divisor| and the new quotient LSB = 1; else the new quotient LSB = 0.
  - rem is WIDTH+1 bits internally so the compare/subtract cannot overflow.
  - After the WIDTH-th cycle, go to FIX.
- FIX, 1 cycle:
  - Negate quotient if sign_q.
  - Negate remainder if sign_r.
  - Load the output registers; go to DONE.
- Normal latency: out_valid rises in cycle T0+WIDTH+2.
- DONE:
  - out_valid = 1; quotient and remainder stay stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE and clear out_valid.
  - in_ready stays low until IDLE; there is no accept in the same cycle as result retirement.
- in_ready = 1 only in IDLE; in_ready = 0 in CALC, FIX and DONE.
- in_valid with in_ready = 0 is ignored; the requester must hold it.
- flush:
  - In any state, flush high at an edge forces IDLE and clears out_valid.
  - It also blocks an accept in that same cycle.
  - Output data registers keep their last value.
- Reset asserted mid-operation aborts immediately; no result is produced.
- Invariants for all non-special cases: dividend == quotient*divisor + remainder (mod 2^WIDTH), and |remainder| < |divisor|.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: at T0, if |dividend| < |divisor| (non-special case), go directly to DONE.
  - quotient = 0, remainder = original dividend.
  - out_valid in cycle T0+1.
- When undefined: this case runs the full CALC/FIX path, latency WIDTH+2.
- Results are bit-identical either way; only latency differs.

Test Plan:
- Unsigned 100 / 7, div_signed = 0 → out_valid at T0+66, quotient = 14, remainder = 2; in_ready low throughout.
- Signed -100 / 7 → quotient = -14 (0xFFFF_FFFF_FFFF_FFF2), remainder = -2 (0xFFFF_FFFF_FFFF_FFFE).
- Signed 100 / -7 → quotient = -14, remainder = 2.
- Divide by zero, dividend = 0x1234 → out_valid at T0+1, quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 0x1234.
- Signed overflow 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → out_valid at T0+1, quotient = 0x8000_0000_0000_0000, remainder = 0.
- Backpressure and abort:
  - Hold out_ready = 0 for 10 cycles after out_valid → outputs stable, in_ready = 0.
  - Then out_ready = 1 → IDLE next cycle.
  - Separately, assert flush in CALC cycle 20 → IDLE, in_ready = 1 next cycle, no out_valid.
  - Assert rst_n low mid-CALC → out_valid = 0 immediately.
- With DIV_EARLY_OUT_EN: unsigned 5 / 9 → out_valid at T0+1, quotient = 0, remainder = 5.
- Without DIV_EARLY_OUT_EN: unsigned 5 / 9 → out_valid at T0+66, quotient = 0, remainder = 5.
